// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the SRAM data-memory controller.
//   - state_e        : access sequencer states
//   - SRAM_ADDR_W    : half-word address width on the SRAM bus
//   - SRAM_DATA_W    : SRAM data bus width
//   - word_index()   : byte address -> 17-bit data-memory word index
package sram_mem_controller_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned WORD_W      = SRAM_ADDR_W - 1;

  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'd1024;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StDone
  } state_e;

  // Rebase, drop the byte offset and keep 17 bits; out-of-range words wrap.
  function automatic logic [WORD_W-1:0] word_index(input logic [31:0] addr,
                                                   input logic [31:0] base);
    return WORD_W'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Phase timer for the SRAM controller.
//   clk, rst   : clock, asynchronous active-high reset
//   restart_i  : force the count back to zero on the next edge
//   last_o     : high on the final cycle of a PHASE_CYCLES-long phase
module sram_phase_counter #(
  parameter int unsigned PHASE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic last_o
);

  localparam int unsigned CntW = $clog2(PHASE_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(PHASE_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (restart_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last_o = (cnt_q == LastCnt);

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage data-memory controller for a 16-bit asynchronous SRAM.
// Each 32-bit access runs as two half-word phases (low half first), each held
// for PHASE_CYCLES clocks, followed by one DONE cycle in which ready is high.
//   clk, rst              : clock, asynchronous active-high reset
//   rd_en, wr_en          : load / store request (store wins if both set)
//   address, write_data   : byte address and store data
//   read_data, ready      : load result, pipeline-freeze release
//   sram_addr             : half-word address
//   sram_dq_out/oe/in     : data bus out, drive enable, data bus in
//   sram_we_n             : active-low write enable
// PHASE_CYCLES must be in 1..15.
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE    = DEFAULT_ADDR_BASE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_we_n
);

  state_e            state_q;
  logic              is_wr_q;
  logic [WORD_W-1:0] word_q;
  logic [31:0]       wdata_q;

  logic              phase_last;
  logic              cnt_restart;
  logic [WORD_W-1:0] req_word;

  assign req_word = word_index(address, ADDR_BASE);

  // Counter runs only inside a phase and restarts at each phase boundary.
  assign cnt_restart = ((state_q != StLow) && (state_q != StHigh)) || phase_last;

  sram_phase_counter #(
    .PHASE_CYCLES(PHASE_CYCLES)
  ) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .restart_i(cnt_restart),
    .last_o   (phase_last)
  );

  // Bus outputs are loaded on the same edge as the state change so they line
  // up with the phase they belong to; they never depend combinationally on
  // the request inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      is_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      read_data   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rd_en || wr_en) begin
            state_q    <= StLow;
            is_wr_q    <= wr_en;
            word_q     <= req_word;
            wdata_q    <= write_data;
            sram_addr  <= {req_word, 1'b0};
            sram_we_n  <= ~wr_en;
            sram_dq_oe <= wr_en;
            if (wr_en) begin
              sram_dq_out <= write_data[15:0];
            end
          end
        end
        StLow: begin
          if (phase_last) begin
            state_q   <= StHigh;
            sram_addr <= {word_q, 1'b1};
            if (is_wr_q) begin
              sram_dq_out <= wdata_q[31:16];
            end else begin
              read_data[15:0] <= sram_dq_in;
            end
          end
        end
        StHigh: begin
          if (phase_last) begin
            state_q    <= StDone;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!is_wr_q) begin
              read_data[31:16] <= sram_dq_in;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ready = (state_q == StDone) || ((state_q == StIdle) && !rd_en && !wr_en);

endmodule
